// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_pkg
//  Description : Shared opcode encodings, sequencer state encoding and a small
//                opcode-classification helper for the 4-bit CPU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_sequencer_pkg;

    // Opcode field IR[7:4]
    localparam logic [3:0] c_OP_NOP      = 4'b0000;
    localparam logic [3:0] c_OP_ADD_A_IM = 4'b0001;
    localparam logic [3:0] c_OP_ADD_B_IM = 4'b0010;
    localparam logic [3:0] c_OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] c_OP_JMP_IM   = 4'b1111;

    // Values are architecturally visible on state_out, so they are pinned.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

    // Only the immediate-add instructions produce a meaningful ALU carry.
    function automatic logic is_add_op(input logic [3:0] op);
        return (op == c_OP_ADD_A_IM) || (op == c_OP_ADD_B_IM);
    endfunction

endpackage : cpu_sequencer_pkg
`default_nettype wire

// File: rtl/cpu_sequencer_ack_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ack_timer
//  Description : Counts FETCH cycles spent waiting for the ROM acknowledge.
//                'expired' flags the cycle that is the ACK_TIMEOUT-th
//                consecutive enabled cycle, so the caller can leave FETCH on
//                the following edge.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                clear        - return count to zero (wins over enable)
//                enable       - count this cycle
//                expired      - combinational, high on the last allowed cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] c_LAST_COUNT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Decoded combinationally so the fault transition happens exactly after
    // ACK_TIMEOUT unacknowledged cycles, not one later.
    assign expired = enable && (r_count == c_LAST_COUNT);

endmodule : seq_ack_timer
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Fetch/execute controller for the 4-bit CPU. Owns PC, IR and
//                the carry flag, fetches instructions over a req/ack
//                handshake, issues a one-cycle execute strobe and resolves
//                JMP/JNC.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                run                  - continuous fetch/execute enable
//                step_req             - single-step request (CPU_SEQ_STEP_EN)
//                rom_req/rom_addr     - fetch request and address (= PC)
//                rom_ack/rom_data     - ROM handshake and instruction byte
//                op_out/imm_out       - IR opcode / immediate fields
//                exec_en              - execute strobe qualifying reg loads
//                carry_in/carry_flag  - ALU carry-out / registered carry
//                pc_out, state_out    - PC and FSM state
//                fault                - ROM acknowledge timeout (absorbing)
//  Options     : define CPU_SEQ_STEP_EN to add the step_req single-step port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [3:0]  RESET_PC    = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
`ifdef CPU_SEQ_STEP_EN
    input  logic       step_req,
`endif
    output logic       rom_req,
    output logic [3:0] rom_addr,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    output logic [3:0] op_out,
    output logic [3:0] imm_out,
    output logic       exec_en,
    input  logic       carry_in,
    output logic       carry_flag,
    output logic [3:0] pc_out,
    output logic [1:0] state_out,
    output logic       fault
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic       r_carry;

    logic [3:0] w_op;
    logic [3:0] w_imm;
    logic [3:0] w_pc_exec;

    logic       w_timer_clear;
    logic       w_timer_en;
    logic       w_timer_expired;

    // w_step_go  : IDLE may start a single FETCH+EXEC
    // w_step_hold: the instruction in flight is a single step, so EXEC must
    //              fall back to IDLE whatever run says
    logic       w_step_go;
    logic       w_step_hold;

    assign w_op  = r_ir[7:4];
    assign w_imm = r_ir[3:0];

    // ------------------------------------------------------------------------
    // Optional single-step support
    // ------------------------------------------------------------------------
`ifdef CPU_SEQ_STEP_EN
    logic r_step_mode;

    // Re-evaluated on every IDLE cycle and held through FETCH/EXEC; run wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_mode <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_step_mode <= !run && step_req;
        end
    end

    assign w_step_go   = step_req;
    assign w_step_hold = r_step_mode;
`else
    assign w_step_go   = 1'b0;
    assign w_step_hold = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // ROM acknowledge timeout
    // ------------------------------------------------------------------------
    seq_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_timer_expired)
    );

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        rom_req       = 1'b0;
        exec_en       = 1'b0;
        fault         = 1'b0;
        w_timer_clear = 1'b1;
        w_timer_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run || w_step_go) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                rom_req       = 1'b1;
                w_timer_clear = rom_ack;
                w_timer_en    = !rom_ack;
                // An ack on the final allowed cycle still completes the fetch.
                if (rom_ack) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_timer_expired) begin
                    w_state_nxt = ST_FAULT;
                end
            end

            ST_EXEC: begin
                exec_en = 1'b1;
                if (run && !w_step_hold) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next PC at the end of EXEC. JNC looks at the carry produced by the
    // previous instruction, i.e. the flag before this EXEC updates it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_exec = r_pc + 4'd1;
        case (w_op)
            c_OP_JMP_IM: w_pc_exec = w_imm;
            c_OP_JNC_IM: if (!r_carry) w_pc_exec = w_imm;
            default:     w_pc_exec = r_pc + 4'd1;
        endcase
    end

    // ------------------------------------------------------------------------
    // PC / IR / carry
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= {c_OP_NOP, 4'h0};
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (rom_ack) begin
                        r_ir <= rom_data;
                    end
                end
                ST_EXEC: begin
                    r_pc    <= w_pc_exec;
                    r_carry <= is_add_op(w_op) ? carry_in : 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr   = r_pc;
    assign pc_out     = r_pc;
    assign op_out     = w_op;
    assign imm_out    = w_imm;
    assign carry_flag = r_carry;
    assign state_out  = r_state;

endmodule : cpu_sequencer
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer: table-driven
//                instruction vectors, randomized programs against an
//                instruction-level reference model, and directed multi-cycle
//                sequences (timeout, run drop, reset in EXEC, stray ack).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int unsigned TO  = 15;
    localparam logic [3:0]  RPC = 4'h3;

    logic       clk = 1'b0;
    logic       reset, run, rom_ack, carry_in;
    logic [7:0] rom_data;
    logic       rom_req, exec_en, carry_flag, fault;
    logic [3:0] rom_addr, op_out, imm_out, pc_out;
    logic [1:0] state_out;
`ifdef CPU_SEQ_STEP_EN
    logic       step_req;
`endif

    cpu_sequencer #(
        .ACK_TIMEOUT (TO),
        .RESET_PC    (RPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
`ifdef CPU_SEQ_STEP_EN
        .step_req   (step_req),
`endif
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .op_out     (op_out),
        .imm_out    (imm_out),
        .exec_en    (exec_en),
        .carry_in   (carry_in),
        .carry_flag (carry_flag),
        .pc_out     (pc_out),
        .state_out  (state_out),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Observations taken during the EXEC cycle of the last instruction
    logic [7:0] last_instr;
    logic [3:0] obs_addr, obs_op, obs_imm, obs_pc;
    logic       obs_carry;
    int         exec_cyc;

    typedef struct {
        logic [3:0] pc0;
        logic       c0;
        logic [7:0] instr;
        logic       cin;
        logic [3:0] exp_pc;
        logic       exp_c;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        run      = 1'b0;
        rom_ack  = 1'b0;
        rom_data = 8'h00;
        carry_in = 1'b0;
`ifdef CPU_SEQ_STEP_EN
        step_req = 1'b0;
`endif
        tick;
        tick;
        reset      = 1'b0;
        last_instr = {c_OP_NOP, 4'h0};
    endtask

    // Wait for a fetch, hold off the ack for 'delay' cycles, then ack with
    // 'instr'. Returns with the DUT in its EXEC cycle.
    task automatic fetch_to_exec(input logic [7:0] instr, input int delay);
        int n = 0;
        while (!rom_req && n < 8) begin
            tick;
            n++;
        end
        chk("fetch_req", {31'd0, rom_req}, 32'd1);
        obs_addr = rom_addr;
        for (int i = 0; i < delay; i++) begin
            rom_ack  = 1'b0;
            rom_data = 8'($urandom);
            tick;
            chk("fetch_wait_state", {30'd0, state_out}, 32'd1);
            chk("ir_hold_no_ack", {28'd0, op_out}, {28'd0, last_instr[7:4]});
        end
        rom_ack  = 1'b1;
        rom_data = instr;
        tick;
        rom_ack    = 1'b0;
        rom_data   = 8'($urandom);
        last_instr = instr;
        exec_cyc   = cyc;
        chk("exec_strobe", {31'd0, exec_en}, 32'd1);
    endtask

    task automatic do_instr(input logic [7:0] instr, input logic cin, input int delay);
        fetch_to_exec(instr, delay);
        carry_in  = cin;
        obs_op    = op_out;
        obs_imm   = imm_out;
        obs_pc    = pc_out;
        obs_carry = carry_flag;
        tick;
        carry_in = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prog[16];
        logic [3:0] pc_m, npc, op;
        logic       c_m, cin;
        int         d, prev_exec, fcycles;

        // ---------------- reset state ----------------
        do_reset;
        chk("rst_state",   {30'd0, state_out},  32'd0);
        chk("rst_pc",      {28'd0, pc_out},     {28'd0, RPC});
        chk("rst_op",      {28'd0, op_out},     {28'd0, c_OP_NOP});
        chk("rst_imm",     {28'd0, imm_out},    32'd0);
        chk("rst_carry",   {31'd0, carry_flag}, 32'd0);
        chk("rst_exec_en", {31'd0, exec_en},    32'd0);
        chk("rst_rom_req", {31'd0, rom_req},    32'd0);
        chk("rst_fault",   {31'd0, fault},      32'd0);

        // ---------------- table-driven single instructions ----------------
        vecs[0]  = '{4'h0, 1'b0, {c_OP_ADD_A_IM, 4'h3}, 1'b1, 4'h1, 1'b1};
        vecs[1]  = '{4'h1, 1'b1, {c_OP_ADD_B_IM, 4'h1}, 1'b0, 4'h2, 1'b0};
        vecs[2]  = '{4'h2, 1'b1, {c_OP_NOP,      4'h0}, 1'b1, 4'h3, 1'b0};
        vecs[3]  = '{4'hF, 1'b0, {c_OP_JMP_IM,   4'h2}, 1'b0, 4'h2, 1'b0};
        vecs[4]  = '{4'hF, 1'b1, {c_OP_NOP,      4'h0}, 1'b0, 4'h0, 1'b0};
        vecs[5]  = '{4'h7, 1'b1, {c_OP_JNC_IM,   4'h5}, 1'b0, 4'h8, 1'b0};
        vecs[6]  = '{4'h7, 1'b0, {c_OP_JNC_IM,   4'h5}, 1'b1, 4'h5, 1'b0};
        vecs[7]  = '{4'h3, 1'b1, {4'h7,          4'h9}, 1'b1, 4'h4, 1'b0};
        vecs[8]  = '{4'h0, 1'b0, {c_OP_JMP_IM,   4'hF}, 1'b1, 4'hF, 1'b0};
        vecs[9]  = '{4'hF, 1'b0, {c_OP_ADD_A_IM, 4'hF}, 1'b1, 4'h0, 1'b1};
        vecs[10] = '{4'hF, 1'b1, {c_OP_JNC_IM,   4'h6}, 1'b0, 4'h0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            do_reset;
            run = 1'b1;
            // Position PC at pc0 with carry c0: JMP to pc0-1, then an add there
            do_instr({c_OP_JMP_IM, vecs[i].pc0 - 4'd1}, 1'b0, 0);
            do_instr({c_OP_ADD_A_IM, 4'h0}, vecs[i].c0, 0);
            do_instr(vecs[i].instr, vecs[i].cin, int'($urandom_range(0, 2)));
            chk($sformatf("vec%0d_exec_pc", i),    {28'd0, obs_pc},     {28'd0, vecs[i].pc0});
            chk($sformatf("vec%0d_exec_carry", i), {31'd0, obs_carry},  {31'd0, vecs[i].c0});
            chk($sformatf("vec%0d_op", i),         {28'd0, obs_op},     {28'd0, vecs[i].instr[7:4]});
            chk($sformatf("vec%0d_next_pc", i),    {28'd0, pc_out},     {28'd0, vecs[i].exp_pc});
            chk($sformatf("vec%0d_carry", i),      {31'd0, carry_flag}, {31'd0, vecs[i].exp_c});
        end

        // ---------------- randomized programs vs instruction-level model ----
        for (int a = 0; a < 16; a++) begin
            case ($urandom_range(0, 5))
                0:       op = c_OP_NOP;
                1:       op = c_OP_ADD_A_IM;
                2:       op = c_OP_ADD_B_IM;
                3:       op = c_OP_JNC_IM;
                4:       op = c_OP_JMP_IM;
                default: op = 4'($urandom);
            endcase
            prog[a] = {op, 4'($urandom)};
        end
        do_reset;
        run       = 1'b1;
        pc_m      = RPC;
        c_m       = 1'b0;
        prev_exec = -1;
        for (int k = 0; k < 60; k++) begin
            d   = int'($urandom_range(0, 3));
            cin = 1'($urandom);
            do_instr(prog[pc_m], cin, d);
            chk("rnd_rom_addr", {28'd0, obs_addr},  {28'd0, pc_m});
            chk("rnd_op",       {28'd0, obs_op},    {28'd0, prog[pc_m][7:4]});
            chk("rnd_imm",      {28'd0, obs_imm},   {28'd0, prog[pc_m][3:0]});
            chk("rnd_exec_pc",  {28'd0, obs_pc},    {28'd0, pc_m});
            chk("rnd_exec_c",   {31'd0, obs_carry}, {31'd0, c_m});
            if (prev_exec >= 0)
                chk("rnd_exec_period", 32'(exec_cyc - prev_exec), 32'(d + 2));
            prev_exec = exec_cyc;
            op = prog[pc_m][7:4];
            if (op == c_OP_JMP_IM)
                npc = prog[pc_m][3:0];
            else if (op == c_OP_JNC_IM && !c_m)
                npc = prog[pc_m][3:0];
            else
                npc = pc_m + 4'd1;
            c_m  = (op == c_OP_ADD_A_IM || op == c_OP_ADD_B_IM) ? cin : 1'b0;
            pc_m = npc;
            chk("rnd_next_pc",  {28'd0, pc_out},     {28'd0, pc_m});
            chk("rnd_carry",    {31'd0, carry_flag}, {31'd0, c_m});
            chk("rnd_exec_low", {31'd0, exec_en},    32'd0);
        end

        // ---------------- ack on the last allowed FETCH cycle ----------------
        do_reset;
        run = 1'b1;
        do_instr({c_OP_NOP, 4'h0}, 1'b0, int'(TO) - 1);
        chk("late_ack_pc", {28'd0, pc_out}, {28'd0, RPC + 4'd1});

        // ---------------- timeout -> FAULT ----------------
        do_reset;
        run = 1'b1;
        tick;
        fcycles = 0;
        while (state_out == 2'd1 && fcycles < 3 * int'(TO)) begin
            fcycles++;
            rom_data = 8'($urandom);
            tick;
        end
        chk("timeout_fetch_len", 32'(fcycles), 32'(TO));
        chk("fault_state",   {30'd0, state_out}, 32'd3);
        chk("fault_flag",    {31'd0, fault},     32'd1);
        chk("fault_rom_req", {31'd0, rom_req},   32'd0);
        rom_ack  = 1'b1;
        rom_data = {c_OP_JMP_IM, 4'hA};
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fault_sticky",  {30'd0, state_out}, 32'd3);
            chk("fault_no_exec", {31'd0, exec_en},   32'd0);
            chk("fault_pc_frz",  {28'd0, pc_out},    {28'd0, RPC});
            chk("fault_ir_frz",  {28'd0, op_out},    {28'd0, c_OP_NOP});
        end
        do_reset;
        chk("fault_cleared", {31'd0, fault},     32'd0);
        chk("fault_to_idle", {30'd0, state_out}, 32'd0);

        // ---------------- run dropped during FETCH ----------------
        run = 1'b1;
        tick;
        run = 1'b0;
        do_instr({c_OP_ADD_A_IM, 4'h9}, 1'b1, 2);
        chk("rundrop_idle",  {30'd0, state_out},  32'd0);
        chk("rundrop_req",   {31'd0, rom_req},    32'd0);
        chk("rundrop_pc",    {28'd0, pc_out},     {28'd0, RPC + 4'd1});
        chk("rundrop_carry", {31'd0, carry_flag}, 32'd1);
        // Stray acks in IDLE must not load IR or start anything
        rom_ack  = 1'b1;
        rom_data = {c_OP_JMP_IM, 4'h5};
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stray_ack_idle", {30'd0, state_out}, 32'd0);
            chk("stray_ack_ir",   {28'd0, op_out},    {28'd0, c_OP_ADD_A_IM});
            chk("stray_ack_pc",   {28'd0, pc_out},    {28'd0, RPC + 4'd1});
        end
        rom_ack = 1'b0;

        // ---------------- reset asserted in EXEC ----------------
        do_reset;
        run = 1'b1;
        fetch_to_exec({c_OP_ADD_B_IM, 4'h1}, 0);
        carry_in = 1'b1;
        reset    = 1'b1;
        tick;
        reset      = 1'b0;
        carry_in   = 1'b0;
        last_instr = {c_OP_NOP, 4'h0};
        chk("rst_exec_state", {30'd0, state_out},  32'd0);
        chk("rst_exec_pc",    {28'd0, pc_out},     {28'd0, RPC});
        chk("rst_exec_carry", {31'd0, carry_flag}, 32'd0);
        chk("rst_exec_en",    {31'd0, exec_en},    32'd0);
        chk("rst_exec_ir",    {28'd0, op_out},     {28'd0, c_OP_NOP});

`ifdef CPU_SEQ_STEP_EN
        // ---------------- single step ----------------
        do_reset;
        step_req = 1'b1;
        tick;
        chk("step_fetch", {30'd0, state_out}, 32'd1);
        // still high through FETCH: must not chain a second instruction
        fetch_to_exec({c_OP_NOP, 4'h0}, 1);
        step_req = 1'b0;
        tick;
        chk("step_idle", {30'd0, state_out}, 32'd0);
        chk("step_pc",   {28'd0, pc_out},    {28'd0, RPC + 4'd1});
        d = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (exec_en) d++;
        end
        chk("step_no_extra_exec", 32'(d), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu_sequencer
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/execute controller for the 4-bit CPU.
- Owns the program counter (PC), instruction register (IR) and carry flag.
- Fetches 8-bit instructions from program ROM over a req/ack handshake and presents the opcode to the instruction decoder.
- Qualifies register loads with a one-cycle execute strobe and resolves jumps.

Parameters:
- ACK_TIMEOUT, 15: max FETCH cycles waiting for rom_ack before fault (1..255).
- RESET_PC, 4'h0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = fetch/execute continuously; 0 = stop at next instruction boundary.
- rom_req  out  1  fetch request; held high throughout FETCH.
- rom_addr  out  4  fetch address, equals pc_out.
- rom_ack  in  1  ROM has valid rom_data this cycle.
- rom_data  in  8  instruction: [7:4] opcode, [3:0] immediate.
- op_out  out  4  IR[7:4]; drives decoder op_in.
- imm_out  out  4  IR[3:0]; immediate to ALU.
- exec_en  out  1  one-cycle strobe; register loads are decoder load AND exec_en.
- carry_in  in  1  ALU carry-out for the current IR.
- carry_flag  out  1  registered carry.
- pc_out  out  4  current PC.
- state_out  out  2  FSM state (IDLE=0, FETCH=1, EXEC=2, FAULT=3).
- fault  out  1  sticky ROM timeout indication.

Behaviour:
- Reset values: state IDLE; PC=RESET_PC; IR={OP_NOP,4'h0}; carry_flag=0; exec_en=0; rom_req=0; fault=0; timeout counter=0.
- IDLE:
  - rom_req=0.
  - run=1 -> FETCH next cycle.
- FETCH:
  - rom_req=1, rom_addr=PC.
  - Timeout counter increments each cycle rom_ack=0.
  - rom_ack=1 -> IR<=rom_data, counter<=0, -> EXEC. Ack is accepted in the first FETCH cycle.
  - Counter reaching ACK_TIMEOUT with no ack -> FAULT.
  - run deasserting during FETCH does not abort the fetch.
- EXEC (exactly one cycle):
  - exec_en=1, rom_req=0.
  - Carry: OP_ADD_A_IM / OP_ADD_B_IM -> carry_flag<=carry_in; all other ops -> carry_flag<=0.
  - Next PC: OP_JMP_IM -> imm. OP_JNC_IM -> imm if carry_flag==0, else PC+1. JNC tests the pre-update flag. All other ops -> PC+1.
  - PC wraps 4'hF -> 4'h0.
  - Next state: run=1 -> FETCH; else IDLE.
- FAULT:
  - Absorbing state; exits only on reset.
  - fault=1, rom_req=0, exec_en=0; PC and IR frozen.
- Unknown opcodes: executed as NOP (PC+1, carry cleared, exec_en still pulses).
- Throughput: 2 cycles per instruction minimum (FETCH with immediate ack + EXEC).
- rom_ack outside FETCH is ignored.
- Reset in any state, including mid-FETCH or EXEC, takes priority: all registers return to reset values the next cycle, and no exec_en is issued.

Optional Feature:
- CPU_SEQ_STEP_EN defined:
  - Adds input port step_req (1 bit).
  - In IDLE with run=0, a step_req=1 cycle runs exactly one FETCH+EXEC, then returns to IDLE regardless of run.
  - step_req is ignored outside IDLE.
  - run=1 takes precedence over step_req.
- CPU_SEQ_STEP_EN undefined: step_req port is absent; behaviour is controlled only by run.

Decomposition:
- defines.v (shared):
  - New opcodes OP_JMP_IM=4'b1111 and OP_JNC_IM=4'b1110, alongside existing OP_NOP, OP_ADD_A_IM, OP_ADD_B_IM.
  - State encodings ST_IDLE, ST_FETCH, ST_EXEC, ST_FAULT.
- Sub-module seq_ack_timer: counter with clear/enable inputs, ACK_TIMEOUT parameter and expired output.
- PC/IR/carry/FSM logic stays in cpu_sequencer.

Test Plan:
- Reset, run=1, ROM acks immediately, program {ADD_A_IM 3, ADD_B_IM 1, NOP} -> pc_out 0,1,2 on successive EXECs; exec_en high every 2nd cycle; op_out matches each opcode.
- Addition overflow with carry_in=1 on ADD_A_IM, then OP_JNC_IM 4'h5 -> carry_flag=1, no jump, PC=prev+1, carry_flag cleared. Repeat with carry_in=0 -> PC=5.
- OP_JMP_IM 4'h2 at PC=4'hF; separately NOP at PC=4'hF -> PC=2 after the jump; PC=0 after the NOP (wrap).
- rom_ack delayed 3 cycles -> FETCH lasts 4 cycles; IR latches data only on the ack cycle. No ack for ACK_TIMEOUT cycles -> state_out=3, fault=1, rom_req=0 until reset.
- run dropped during FETCH -> current instruction completes EXEC, then IDLE with rom_req=0. reset asserted in EXEC -> next cycle state IDLE, PC=RESET_PC, carry_flag=0, exec_en=0.
- With CPU_SEQ_STEP_EN, run=0, one step_req pulse -> exactly one exec_en pulse, PC+1, return to IDLE; step_req during FETCH is ignored.
